elevator_request_queue: RTL and testbench
=========================================

# elevator_request_queue

Upstream request stage for the elevator controller. It edge-detects per-floor call buttons and latches each press until it can be queued. It de-duplicates floors already waiting, suppresses calls for the car's current floor, and presents accepted floor numbers through a first-word-fall-through FIFO read port. The elevator FSM consumes that port via `fifo_empty` / `fifo_dout` / `fifo_rd`.

## Interface
- `FLOORS`, default 16: number of floors/buttons (2..16); floor numbers are 4-bit.
- `DEPTH`, default 8: FIFO entries; power of two, 2..16.
- `AW`, default 3: pointer width, log2(`DEPTH`).

Ports:
- `clk` in 1: clock, all state updates on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req_btn` in `FLOORS`: call buttons, level, already synchronous to `clk`; bit i = floor i.
- `cur_floor` in 4: car's current floor from the FSM.
- `fifo_rd` in 1: pop strobe from the FSM; head is consumed at the edge where it is sampled high.
- `fifo_empty` out 1: no entries queued.
- `fifo_full` out 1: `DEPTH` entries queued.
- `fifo_dout` out 4: head floor number, valid when `fifo_empty`=0; 0 when empty.
- `pending` out `FLOORS`: bit i set while floor i is in the queue (call lamps).
- `q_count` out `AW`+1: number of queued entries.

## Operation
Registers:
- `btn_q` holds the previous value of `req_btn`.
- `arm` is the latched-press vector.
- `mem` holds the FIFO storage.
- `wr_ptr`/`rd_ptr` are `AW` bits and wrap modulo `DEPTH`.
- `count` holds the entry count.
- `pending` is the queued-floor vector.

Edge capture:
- `rise = req_btn & ~btn_q`.
- Each edge: `arm <= (arm | rise) & ~clr`, where `clr` is the one-hot bit selected below.
- `btn_q <= req_btn`.

Selection, combinational from current registers:
- `sel` = lowest index i with `arm[i]`=1.
- No selection when `arm`=0.

Disposition of `sel`, evaluated in priority order:
- `pending[sel]`=1: duplicate. Clear `arm[sel]`, no push.
- `sel` == `cur_floor`: current-floor call. Clear `arm[sel]`, no push.
- `fifo_full`=1: hold. `arm[sel]` stays set; the press is not lost.
- Otherwise: push. Write `mem[wr_ptr]`=`sel`, increment `wr_ptr`, set `pending[sel]`, clear `arm[sel]`.

Throughput:
- At most one `arm` bit is resolved per cycle.
- Simultaneous presses drain lowest-floor-first, one per cycle.

Pop:
- `fifo_rd`=1 with `fifo_empty`=0 increments `rd_ptr` and clears `pending[mem[rd_ptr]]`.
- `fifo_rd` while empty is ignored; no pointer or count change.

Count and flags:
- Push and pop in the same cycle: both take effect, `count` unchanged.
- `fifo_empty` = (`count`==0); `fifo_full` = (`count`==`DEPTH`); both decoded from registered `count`.
- `fifo_dout` = `mem[rd_ptr]`, forced to 0 when empty.

Same-floor push/pop in one cycle:
- Cannot occur, because the `pending` bit blocks the push.
- The popped floor's `arm` bit stays set if re-pressed and is pushed the following cycle.

Reset values:
- Reset asserted: `arm`=0, `pending`=0, pointers=0, `count`=0.
- Outputs after reset: `fifo_empty`=1, `fifo_full`=0, `fifo_dout`=0, `q_count`=0.
- `btn_q` resets to all-ones, so buttons held through reset do not generate requests until released and pressed again.
- Reset mid-operation discards all queued and armed requests immediately (asynchronous).
- `mem` contents are not reset.

## Timing
- Press latency: `req_btn[i]` first sampled high at edge E1 → `arm[i]`=1 after E1. Push at E2 (if `arm[i]` is lowest and not blocked) → `fifo_empty`=0, `fifo_dout`=i, `pending[i]`=1 after E2.
- Pop latency: `fifo_rd` high at edge E → new head, `pending`, `count` and flags updated after E. `fifo_dout` is first-word-fall-through; no read latency.
- Full-to-push: a pop at E frees a slot. A held `arm` bit pushes at E+1 (`count` evaluated from registered value).
- Pointer wrap: after `DEPTH` pushes, `wr_ptr` returns to 0; ordering is preserved across wrap.

## Test plan
- Reset/idle: assert `rst`, hold `req_btn`=16'h0001 through release → `fifo_empty`=1, `pending`=0, `q_count`=0; no push until bit 0 is released and re-pressed.
- Single call: `cur_floor`=0, pulse `req_btn[5]` one cycle → two edges later `fifo_dout`=5, `pending[5]`=1, `q_count`=1. `fifo_rd` one cycle → `fifo_empty`=1, `pending[5]`=0.
- Simultaneous presses: `cur_floor`=0, `req_btn`=16'h0094 for one cycle → pushes 2, 4, 7 on three consecutive edges. Pops return 2, 4, 7 in order.
- Duplicate/current floor: `cur_floor`=3; press 3, then 9 twice while 9 is queued → queue holds only 9, `q_count`=1, `arm`=0.
- Full and wrap: `DEPTH`=8, press floors 1..9 with no pops → `fifo_full`=1, `q_count`=8, floor 9 held armed. One pop → 9 pushed the next cycle. Drain returns 2..9 in order across pointer wrap.
- Concurrent push/pop: queue=[4], press 6 and pulse `fifo_rd` on the push edge → `q_count` stays 1, `fifo_dout`=6, `pending`=bit 6 only. `fifo_rd` while empty → no change.

Source files
------------

// File: rtl/elevator_request_queue.sv
// Call-button request stage: edge-captures presses, de-duplicates queued floors,
// drops current-floor calls and feeds accepted floors into a FWFT FIFO.
module elevator_request_queue #(
  parameter int FLOORS = 16,
  parameter int DEPTH  = 8,
  parameter int AW     = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [FLOORS-1:0] req_btn,
  input  logic [3:0]        cur_floor,
  input  logic              fifo_rd,
  output logic              fifo_empty,
  output logic              fifo_full,
  output logic [3:0]        fifo_dout,
  output logic [FLOORS-1:0] pending,
  output logic [AW:0]       q_count
);

  logic [FLOORS-1:0] btn_q;
  logic [FLOORS-1:0] arm;
  logic [3:0]        mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       count;

  logic [FLOORS-1:0] rise;
  logic [FLOORS-1:0] sel_oh;
  logic [FLOORS-1:0] head_oh;
  logic [FLOORS-1:0] clr;
  logic [3:0]        sel;
  logic              sel_valid;
  logic              is_dup;
  logic              is_cur;
  logic              push;
  logic              pop;
  logic [3:0]        head;

  assign head       = mem[rd_ptr];
  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == (AW+1)'(DEPTH));
  assign fifo_dout  = fifo_empty ? '0 : head;
  assign q_count    = count;
  assign rise       = req_btn & ~btn_q;

  // Lowest armed floor wins; only one request is resolved per cycle.
  always_comb begin
    sel       = '0;
    sel_oh    = '0;
    sel_valid = 1'b0;
    for (int unsigned i = 0; i < FLOORS; i++) begin
      if (arm[i] && !sel_valid) begin
        sel_valid = 1'b1;
        sel       = 4'(i);
        sel_oh[i] = 1'b1;
      end
    end
  end

  always_comb begin
    head_oh = '0;
    for (int unsigned i = 0; i < FLOORS; i++) begin
      head_oh[i] = (head == 4'(i));
    end
  end

  // A full FIFO holds the armed bit so the press survives until a slot frees.
  always_comb begin
    is_dup = |(pending & sel_oh);
    is_cur = (sel == cur_floor);
    push   = sel_valid && !is_dup && !is_cur && !fifo_full;
    pop    = fifo_rd && !fifo_empty;
    clr    = (is_dup || is_cur || !fifo_full) ? sel_oh : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_q   <= '1;
      arm     <= '0;
      pending <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
    end else begin
      btn_q   <= req_btn;
      arm     <= (arm | rise) & ~clr;
      pending <= (pending & ~(pop ? head_oh : '0)) | (push ? sel_oh : '0);
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= sel;
  end

endmodule

// File: tb/tb_elevator_request_queue.sv
// Directed self-checking bench for elevator_request_queue (default parameters).
module tb_elevator_request_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] req_btn;
  logic [3:0]  cur_floor;
  logic        fifo_rd;
  logic        fifo_empty;
  logic        fifo_full;
  logic [3:0]  fifo_dout;
  logic [15:0] pending;
  logic [3:0]  q_count;

  int n_cmp = 0;
  int n_err = 0;

  elevator_request_queue #(.FLOORS(16), .DEPTH(8), .AW(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_btn   (req_btn),
    .cur_floor (cur_floor),
    .fifo_rd   (fifo_rd),
    .fifo_empty(fifo_empty),
    .fifo_full (fifo_full),
    .fifo_dout (fifo_dout),
    .pending   (pending),
    .q_count   (q_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; req_btn = 16'h0001; cur_floor = 4'd2; fifo_rd = 1'b0;
    tick(); tick();
    rst = 1'b0;
    check("rst_empty", fifo_empty, 1);
    check("rst_full", fifo_full, 0);
    check("rst_dout", fifo_dout, 0);
    check("rst_count", q_count, 0);
    check("rst_pending", pending, 0);
    tick(); tick(); tick();
    check("held_btn_no_push", fifo_empty, 1);
    check("held_btn_no_arm", dut.arm, 0);
    req_btn = 16'h0000; tick();
    req_btn = 16'h0001; tick();
    req_btn = 16'h0000; tick();
    check("repress_empty", fifo_empty, 0);
    check("repress_count", q_count, 1);
    check("repress_pending", pending, 16'h0001);
    fifo_rd = 1'b1; tick(); fifo_rd = 1'b0;
    check("repress_pop_empty", fifo_empty, 1);

    // Single call
    cur_floor = 4'd0;
    req_btn = 16'h0020; tick();
    req_btn = 16'h0000;
    check("single_e1_empty", fifo_empty, 1);
    tick();
    check("single_dout", fifo_dout, 5);
    check("single_pending", pending, 16'h0020);
    check("single_count", q_count, 1);
    fifo_rd = 1'b1; tick(); fifo_rd = 1'b0;
    check("single_pop_empty", fifo_empty, 1);
    check("single_pop_pending", pending, 0);

    // Simultaneous presses drain lowest-first
    req_btn = 16'h0094; tick(); req_btn = 16'h0000;
    tick();
    check("simul_dout1", fifo_dout, 2);
    check("simul_count1", q_count, 1);
    tick();
    check("simul_count2", q_count, 2);
    tick();
    check("simul_count3", q_count, 3);
    check("simul_pending", pending, 16'h0094);
    fifo_rd = 1'b1;
    check("simul_pop2", fifo_dout, 2); tick();
    check("simul_pop4", fifo_dout, 4); tick();
    check("simul_pop7", fifo_dout, 7); tick();
    fifo_rd = 1'b0;
    check("simul_drained", fifo_empty, 1);

    // Duplicate and current-floor suppression
    cur_floor = 4'd3;
    req_btn = 16'h0008; tick(); req_btn = 16'h0000; tick();
    check("curfloor_dropped", fifo_empty, 1);
    for (int k = 0; k < 3; k++) begin
      req_btn = 16'h0200; tick(); req_btn = 16'h0000; tick();
    end
    check("dup_count", q_count, 1);
    check("dup_dout", fifo_dout, 9);
    check("dup_arm", dut.arm, 0);
    check("dup_pending", pending, 16'h0200);
    fifo_rd = 1'b1; tick(); fifo_rd = 1'b0;
    cur_floor = 4'd0;

    // Full, hold and pointer wrap
    req_btn = 16'h03FE; tick(); req_btn = 16'h0000;
    for (int k = 0; k < 9; k++) tick();
    check("full_flag", fifo_full, 1);
    check("full_count", q_count, 8);
    check("full_arm_held", dut.arm, 16'h0200);
    check("full_head", fifo_dout, 1);
    fifo_rd = 1'b1; tick(); fifo_rd = 1'b0;
    check("after_pop_count", q_count, 7);
    check("after_pop_full", fifo_full, 0);
    check("after_pop_pending", pending, 16'h01FC);
    tick();
    check("held_pushed_count", q_count, 8);
    check("held_pushed_arm", dut.arm, 0);
    check("held_pushed_pending", pending, 16'h03FC);
    fifo_rd = 1'b1;
    for (int f = 2; f <= 9; f++) begin
      check($sformatf("wrap_drain_%0d", f), fifo_dout, f);
      tick();
    end
    fifo_rd = 1'b0;
    check("wrap_empty", fifo_empty, 1);
    check("wrap_pending", pending, 0);

    // Concurrent push and pop
    req_btn = 16'h0010; tick(); req_btn = 16'h0000; tick();
    check("conc_pre_dout", fifo_dout, 4);
    req_btn = 16'h0040; tick(); req_btn = 16'h0000;
    fifo_rd = 1'b1; tick(); fifo_rd = 1'b0;
    check("conc_count", q_count, 1);
    check("conc_dout", fifo_dout, 6);
    check("conc_pending", pending, 16'h0040);
    fifo_rd = 1'b1; tick();
    check("conc_popped_empty", fifo_empty, 1);
    tick(); fifo_rd = 1'b0;
    check("rd_empty_count", q_count, 0);
    check("rd_empty_flag", fifo_empty, 1);
    check("rd_empty_full", fifo_full, 0);
    check("rd_empty_dout", fifo_dout, 0);
    req_btn = 16'h0008; tick(); req_btn = 16'h0000; tick();
    check("post_rd_empty_dout", fifo_dout, 3);
    check("post_rd_empty_count", q_count, 1);

    // Asynchronous reset mid-operation
    #2 rst = 1'b1; #1;
    check("async_rst_empty", fifo_empty, 1);
    check("async_rst_pending", pending, 0);
    tick(); rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
